// File: rtl/reg_file_dump_if.sv
// rtl/reg_file_dump_if.sv - register-file dump sequencer bus: start/range, read port A, word stream
interface reg_file_dump_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_addr, last_addr, rd_data, out_ready,
    output rd_addr, out_data, out_addr, out_valid, busy, done
  );

  modport slave (
    output start, first_addr, last_addr, rd_data, out_ready,
    input  rd_addr, out_data, out_addr, out_valid, busy, done
  );
endinterface

// File: rtl/reg_file_dump.sv
// rtl/reg_file_dump.sv - sweeps register file read port A over a wrapping range and streams each word
module reg_file_dump #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           nClear,
  reg_file_dump_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_READ    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cur_d   = bus.first_addr;
          last_d  = bus.last_addr;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Snapshot here so later changes to the register are not reflected downstream.
        out_data_d  = bus.rd_data;
        out_addr_d  = cur_q;
        out_valid_d = 1'b1;
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          if (cur_q == last_q) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nClear) begin
    if (!nClear) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Read port A is only claimed while reading/presenting; elsewhere the datapath owns it.
  assign bus.rd_addr   = (state_q == S_READ || state_q == S_PRESENT) ? cur_q : '0;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// tb/tb_reg_file_dump.sv - directed self-checking bench for reg_file_dump
module tb_reg_file_dump;
  logic clk;
  logic nClear;
  logic [15:0] rf [16];
  int n_tests;
  int n_fail;

  reg_file_dump_if bus ();

  reg_file_dump dut (
    .clk    (clk),
    .nClear (nClear),
    .bus    (bus)
  );

  assign bus.rd_data = rf[bus.rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // stall_addr >= 16 disables the stall; inj_cyc < 0 disables the mid-dump start;
  // start_in_done pulses start during the DONE cycle.
  task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int nexp,
                          input int stall_addr, input int inj_cyc, input bit start_in_done,
                          input string tag);
    int acc = 0;
    int dones = 0;
    int last_cyc = -1;
    int cyc;
    bit stalled = 0;
    logic [3:0]  ea;
    logic [15:0] saved;
    bus.first_addr = f;
    bus.last_addr  = l;
    bus.out_ready  = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy_after_start"}, bus.busy, 1);
    check({tag, "_rd_addr_read"}, bus.rd_addr, f);
    check({tag, "_valid_in_read"}, bus.out_valid, 0);
    for (cyc = 0; cyc < 200 && !(dones > 0 && !bus.busy); cyc++) begin
      bus.start = 1'b0;
      if (inj_cyc >= 0 && cyc == inj_cyc) begin
        bus.start      = 1'b1;
        bus.first_addr = 4'd9;
        bus.last_addr  = 4'd9;
      end
      if (!stalled && bus.out_valid && bus.out_addr == stall_addr[3:0] && stall_addr < 16) begin
        stalled = 1;
        bus.out_ready = 1'b0;
        saved = rf[stall_addr[3:0]];
        rf[stall_addr[3:0]] = 16'hBEEF;
        for (int k = 0; k < 5; k++) begin
          tick();
          check({tag, "_stall_valid"}, bus.out_valid, 1);
          check({tag, "_stall_addr"}, bus.out_addr, stall_addr);
          check({tag, "_stall_data"}, bus.out_data, stall_addr + 1);
          check({tag, "_stall_rd_addr"}, bus.rd_addr, stall_addr);
        end
        rf[stall_addr[3:0]] = saved;
        bus.out_ready = 1'b1;
        last_cyc = -1;
      end
      if (bus.out_valid && bus.out_ready) begin
        ea = f + acc[3:0];
        check({tag, "_out_addr"}, bus.out_addr, ea);
        check({tag, "_out_data"}, bus.out_data, {12'd0, ea} + 16'd1);
        if (last_cyc >= 0) check({tag, "_spacing"}, cyc - last_cyc, 2);
        last_cyc = cyc;
        acc++;
      end
      if (bus.done) begin
        dones++;
        check({tag, "_done_after_last"}, cyc - last_cyc, 1);
        if (start_in_done) begin
          bus.start      = 1'b1;
          bus.first_addr = 4'd9;
          bus.last_addr  = 4'd9;
        end
      end
      tick();
    end
    bus.start = 1'b0;
    check({tag, "_accepts"}, acc, nexp);
    check({tag, "_done_pulses"}, dones, 1);
    check({tag, "_idle_busy"}, bus.busy, 0);
    check({tag, "_idle_rd_addr"}, bus.rd_addr, 0);
    tick();
    check({tag, "_stays_idle"}, bus.busy, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'(i + 1);
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.out_ready  = 1'b0;
    nClear = 1'b0;
    #23;
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_addr", bus.out_addr, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    nClear = 1'b1;
    tick();
    check("idle_no_start", bus.busy, 0);

    run_dump(4'd1,  4'd4,  4,  99, -1, 0, "basic");
    run_dump(4'd14, 4'd1,  4,  99, -1, 0, "wrap");
    run_dump(4'd7,  4'd7,  1,  99, -1, 1, "single");
    run_dump(4'd1,  4'd4,  4,  2,  -1, 0, "stall");
    run_dump(4'd1,  4'd4,  4,  99, 3,  0, "midstart");
    run_dump(4'd5,  4'd4,  16, 99, -1, 0, "full");

    bus.first_addr = 4'd1;
    bus.last_addr  = 4'd4;
    bus.out_ready  = 1'b0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("pre_rst_valid", bus.out_valid, 1);
    #2;
    nClear = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_addr", bus.out_addr, 0);
    check("mid_rst_rd_addr", bus.rd_addr, 0);
    tick();
    check("held_rst_done", bus.done, 0);
    #2;
    nClear = 1'b1;
    tick();
    run_dump(4'd3, 4'd5, 3, 99, -1, 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
